// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - write-back cache controller FSM with saturating miss counter

module cache_controller #(
  parameter int          INDEX_BITS = 6,
  parameter int          TAG_BITS   = 10,
  parameter logic [15:0] MISS_MAX   = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [31:0]         cpu_addr,
  output logic                cpu_ready,
  output logic                cpu_done,
  input  logic                cache_hit,
  input  logic                cache_valid,
  input  logic                cache_dirty,
  input  logic [TAG_BITS-1:0] victim_tag,
  output logic [31:0]         cache_addr,
  output logic                we_cache,
  output logic                set_valid,
  output logic                set_dirty,
  output logic                sel_mem,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  input  logic                mem_ack,
  output logic [15:0]         miss_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] wb_addr;

  // Victim address keeps the request's upper bits and index, with the stored tag swapped in.
  assign wb_addr = {req_addr[31:INDEX_BITS+TAG_BITS], victim_tag, req_addr[INDEX_BITS-1:0]};

  // State register, request latch and miss counter; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_we     <= 1'b0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && cpu_req) begin
        req_addr <= cpu_addr;
        req_we   <= cpu_we;
      end
      if (state == COMPARE && !cache_hit && miss_count != MISS_MAX) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end

  // Next state and all outputs; line status is echoed back unless this cycle updates the line.
  always_comb begin
    next_state = state;
    cpu_ready  = 1'b0;
    cpu_done   = 1'b0;
    cache_addr = req_addr;
    we_cache   = 1'b0;
    set_valid  = cache_valid & ~rst;
    set_dirty  = cache_dirty & ~rst;
    sel_mem    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: begin
        cpu_ready  = 1'b1;
        cache_addr = cpu_addr;
        if (cpu_req) next_state = COMPARE;
      end
      COMPARE: begin
        if (cache_hit) begin
          cpu_done   = 1'b1;
          next_state = IDLE;
          if (req_we) begin
            we_cache  = 1'b1;
            set_valid = 1'b1;
            set_dirty = 1'b1;
          end
        end else if (cache_valid && cache_dirty) begin
          next_state = WRITEBACK;
        end else begin
          next_state = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = wb_addr;
        if (mem_ack) begin
          set_dirty  = 1'b0;
          next_state = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = req_addr;
        if (mem_ack) begin
          we_cache   = 1'b1;
          sel_mem    = 1'b1;
          set_valid  = 1'b1;
          set_dirty  = 1'b0;
          next_state = COMPARE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - scoreboard bench for cache_controller with cache and memory models

module tb_cache_controller;

  localparam logic [15:0] SAT = 16'd50;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr;
  logic        cpu_ready, cpu_done;
  logic        cache_hit, cache_valid, cache_dirty;
  logic [9:0]  victim_tag;
  logic [31:0] cache_addr;
  logic        we_cache, set_valid, set_dirty, sel_mem;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr;
  logic [15:0] miss_count;

  cache_controller #(.INDEX_BITS(6), .TAG_BITS(10), .MISS_MAX(SAT)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cache_hit(cache_hit),
    .cache_valid(cache_valid), .cache_dirty(cache_dirty), .victim_tag(victim_tag),
    .cache_addr(cache_addr), .we_cache(we_cache), .set_valid(set_valid),
    .set_dirty(set_dirty), .sel_mem(sel_mem), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Cache array model
  logic [63:0] valid_a, dirty_a;
  logic [9:0]  tag_a [64];
  logic [5:0]  idx;
  logic        clr, force_miss, pl_en, pl_v, pl_d;
  logic [5:0]  pl_idx;
  logic [9:0]  pl_tag;

  assign idx         = cache_addr[5:0];
  assign cache_valid = !force_miss && valid_a[idx];
  assign cache_dirty = !force_miss && dirty_a[idx];
  assign cache_hit   = cache_valid && (tag_a[idx] == cache_addr[15:6]);
  assign victim_tag  = tag_a[idx];

  always @(posedge clk) begin
    if (clr) begin
      valid_a <= '0;
      dirty_a <= '0;
      for (int i = 0; i < 64; i++) tag_a[i] <= '0;
    end else if (pl_en) begin
      valid_a[pl_idx] <= pl_v;
      dirty_a[pl_idx] <= pl_d;
      tag_a[pl_idx]   <= pl_tag;
    end else if (!rst) begin
      valid_a[idx] <= set_valid;
      dirty_a[idx] <= set_dirty;
      if (we_cache) tag_a[idx] <= cache_addr[15:6];
    end
  end

  // Memory model: ack arrives mem_wait cycles after mem_req first rises
  int mem_wait;
  int mcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ack <= 1'b0;
      mcnt    <= 0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
      mcnt    <= 0;
    end else if (mem_req) begin
      if (mcnt >= mem_wait - 1) mem_ack <= 1'b1;
      else mcnt <= mcnt + 1;
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    int          wt;
    int          lat;
    int          nmem;
    logic [31:0] wb_addr;
    logic [31:0] rd_addr;
    logic [15:0] miss;
  } vec_t;

  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit keep, output int waits);
    vec_t        e;
    int          lat, nmem;
    logic        txn_we [2];
    logic [31:0] txn_addr [2];
    logic        in_txn, cur_we, stable_bad, fill_ok, done_we, store_ok;
    logic [31:0] cur_addr;
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; mem_wait = v.wt;
    exp_q.push_back(v);
    waits = 0;
    while (!cpu_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      cpu_addr = ~v.addr;
      cpu_we   = ~v.we;
    end
    lat = 0; nmem = 0; in_txn = 0; stable_bad = 0; fill_ok = 0;
    cur_we = 0; cur_addr = 0; done_we = 0; store_ok = 0;
    txn_we[0] = 0; txn_we[1] = 0; txn_addr[0] = 0; txn_addr[1] = 0;
    while (lat < 500) begin
      @(negedge clk);
      lat++;
      if (mem_req) begin
        if (!in_txn) begin
          in_txn = 1; cur_we = mem_we; cur_addr = mem_addr;
        end else if (mem_we !== cur_we || mem_addr !== cur_addr) begin
          stable_bad = 1;
        end
        if (mem_ack) begin
          if (nmem < 2) begin
            txn_we[nmem] = mem_we; txn_addr[nmem] = mem_addr;
          end
          nmem++;
          in_txn = 0;
          if (!mem_we) fill_ok = we_cache && sel_mem && set_valid && !set_dirty;
        end
      end
      if (cpu_done) begin
        done_we  = we_cache;
        store_ok = we_cache && !sel_mem && set_valid && set_dirty;
        break;
      end
    end
    if (!cpu_done) begin
      check("done_timeout", 32'd1, 32'd0);
    end else if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("latency", lat, e.lat);
      check("mem_txns", nmem, e.nmem);
      if (e.nmem == 2) begin
        check("wb_we", txn_we[0], 1);
        check("wb_addr", txn_addr[0], e.wb_addr);
        check("rd_we", txn_we[1], 0);
        check("rd_addr", txn_addr[1], e.rd_addr);
      end else if (e.nmem == 1) begin
        check("rd_we", txn_we[0], 0);
        check("rd_addr", txn_addr[0], e.rd_addr);
      end
      if (e.nmem > 0) begin
        check("mem_stable", stable_bad, 0);
        check("fill_ctl", fill_ok, 1);
      end
      check("done_we", done_we, e.we);
      if (e.we) check("store_ctl", store_ok, 1);
      check("miss_count", miss_count, e.miss);
    end
    if (!keep) cpu_req = 1'b0;
  endtask

  task automatic preload(input logic [5:0] i, input logic v, input logic d, input logic [9:0] t);
    pl_en = 1; pl_idx = i; pl_v = v; pl_d = d; pl_tag = t;
    @(negedge clk);
    pl_en = 0;
  endtask

  vec_t vt [9];
  vec_t vr;
  int   w;
  int   acks;
  int   cyc;

  initial begin
    vt[0] = '{1'b0, 32'h0000_0045, 2, 1, 0, 32'h0, 32'h0, 16'd0};
    vt[1] = '{1'b1, 32'h0000_0045, 2, 1, 0, 32'h0, 32'h0, 16'd0};
    vt[2] = '{1'b0, 32'h0000_0083, 3, 6, 1, 32'h0, 32'h0000_0083, 16'd1};
    vt[3] = '{1'b1, 32'h0000_0083, 1, 1, 0, 32'h0, 32'h0, 16'd1};
    vt[4] = '{1'b1, 32'h0000_0043, 2, 8, 2, 32'h0000_0083, 32'h0000_0043, 16'd2};
    vt[5] = '{1'b0, 32'h0000_0405, 1, 6, 2, 32'h0000_0045, 32'h0000_0405, 16'd3};
    vt[6] = '{1'b1, 32'hABCD_0B83, 1, 6, 2, 32'hABCD_0043, 32'hABCD_0B83, 16'd4};
    vt[7] = '{1'b0, 32'h0000_0007, 4, 7, 1, 32'h0, 32'h0000_0007, 16'd5};
    vt[8] = '{1'b0, 32'h0000_0007, 1, 1, 0, 32'h0, 32'h0, 16'd5};

    rst = 1; clr = 1; force_miss = 0; pl_en = 0; pl_v = 0; pl_d = 0; pl_idx = 0; pl_tag = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 32'h1234_5678; mem_wait = 1;
    #2;
    check("rst_cpu_ready", cpu_ready, 1);
    check("rst_cpu_done", cpu_done, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_we_cache", we_cache, 0);
    check("rst_set_valid", set_valid, 0);
    check("rst_miss_count", miss_count, 0);
    check("rst_cache_addr", cache_addr, 32'h1234_5678);
    @(negedge clk);
    clr = 0;
    preload(6'h05, 1'b1, 1'b0, 10'h001);
    rst = 0;

    for (int i = 0; i < 9; i++) run_vec(vt[i], 1'b0, w);

    // back-to-back: request held through done is re-accepted after one idle cycle
    run_vec(vt[8], 1'b1, w);
    run_vec(vt[8], 1'b0, w);
    check("b2b_idle_cycles", w, 1);

    // reset in the middle of ALLOCATE
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0009; mem_wait = 10;
    cyc = 0;
    while (!mem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("alloc_reached", mem_req, 1);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1;
    #1;
    check("rst_drops_mem_req", mem_req, 0);
    check("rst_ready", cpu_ready, 1);
    check("rst_we_cache_mid", we_cache, 0);
    check("rst_miss_clear", miss_count, 0);
    @(negedge clk);
    check("rst_no_fill", valid_a[9], 0);
    rst = 0;
    vr = '{1'b0, 32'h0000_0009, 1, 4, 1, 32'h0, 32'h0000_0009, 16'd1};
    run_vec(vr, 1'b0, w);
    check("accept_after_rst", w, 0);

    // miss counter saturation: force repeated misses
    @(negedge clk);
    force_miss = 1; mem_wait = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0100;
    acks = 0; cyc = 0;
    while (acks < int'(SAT) && cyc < 4 * int'(SAT) + 50) begin
      @(negedge clk);
      cyc++;
      if (mem_req && mem_ack && !mem_we) begin
        acks++;
        if (acks == int'(SAT) - 2) check("miss_below_sat", miss_count, SAT - 16'd1);
        if (acks == int'(SAT) - 1) check("miss_at_sat", miss_count, SAT);
        if (acks == int'(SAT)) check("miss_saturated", miss_count, SAT);
      end
    end
    check("sat_acks", acks, SAT);
    force_miss = 0;
    cyc = 0;
    while (!cpu_done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("sat_final_done", cpu_done, 1);
    check("sat_final_count", miss_count, SAT);
    cpu_req = 0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
